aes_key_expansion: RTL and testbench

//  Iterative AES key-schedule generator (FIPS-197 KeyExpansion) for AES-128/192/256.
//  On a start pulse, captures the cipher key and computes one 32-bit round-key word per clock.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_key_expansion_if.sv | 14 +
 rtl/sBox.sv | 9 +
 rtl/aes_key_expansion.sv | 84 ++++++++
 tb/tb_aes_key_expansion.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: word width, FIPS-197 S-box table and round-constant lookup.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    return SBOX[b];
  endfunction

  // Index 0 and anything past 10 deliberately map to zero.
  function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Key-expansion request/result bundle; bit 0 of key and keyschedule is the MSB.
interface aes_key_expansion_if #(
  parameter int nk = 4,
  parameter int nr = 10
);
  logic                      start;
  logic [0:32*nk-1]          key;
  logic                      busy;
  logic                      valid;
  logic [0:128*(nr+1)-1]     keyschedule;

  modport master (output start, key, input busy, valid, keyschedule);
  modport slave  (input start, key, output busy, valid, keyschedule);
endinterface

// File: rtl/sBox.sv
// Combinational AES S-box byte substitution.
module sBox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in,
  output logic [BYTE_W-1:0] out
);
  assign out = sbox(in);
endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES key schedule: one 32-bit round-key word per clock after an accepted start.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic clk,
  input  logic rst_n,
  aes_key_expansion_if.slave kif
);
  localparam int NW = 4 * (nr + 1);
  localparam int IW = $clog2(NW);

  logic [WORD_W-1:0] w_q [NW];
  logic [IW-1:0]     idx_q;
  logic [2:0]        pos_q;   // i % nk, tracked incrementally instead of dividing
  logic [3:0]        rnd_q;   // i / nk, selects the round constant
  logic              busy_q;
  logic              valid_q;

  logic [WORD_W-1:0] prev_w, old_w, sub_in, sub_out, temp_w, new_w_d;

  assign prev_w = w_q[idx_q - IW'(1)];
  assign old_w  = w_q[idx_q - IW'(nk)];
  assign sub_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sBox u_sbox (
      .in  (sub_in[8*g +: 8]),
      .out (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    if (pos_q == 3'd0) begin
      temp_w = sub_out ^ {rcon(rnd_q), 24'h0};
    end else if (nk == 8 && pos_q == 3'd4) begin
      temp_w = sub_out;
    end
    new_w_d = old_w ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (kif.start && !busy_q) begin
      for (int k = 0; k < nk; k++) w_q[k] <= kif.key[32*k +: 32];
      idx_q   <= IW'(nk);
      pos_q   <= '0;
      rnd_q   <= 4'd1;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      w_q[idx_q] <= new_w_d;
      idx_q      <= idx_q + IW'(1);
      if (pos_q == 3'(nk - 1)) begin
        pos_q <= '0;
        rnd_q <= rnd_q + 4'd1;
      end else begin
        pos_q <= pos_q + 3'd1;
      end
      if (idx_q == IW'(NW - 1)) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign kif.busy  = busy_q;
  assign kif.valid = valid_q;

  always_comb begin
    kif.keyschedule = '0;
    for (int k = 0; k < NW; k++) kif.keyschedule[32*k +: 32] = w_q[k];
  end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench: AES-128/192/256 schedules, latency, start-while-busy, reset abort, key change.
module tb_aes_key_expansion;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;

  always #5 clk = ~clk;

  aes_key_expansion_if #(.nk(4), .nr(10)) if128 ();
  aes_key_expansion_if #(.nk(6), .nr(12)) if192 ();
  aes_key_expansion_if #(.nk(8), .nr(14)) if256 ();

  aes_key_expansion #(.nk(4), .nr(10)) u_dut128 (.clk(clk), .rst_n(rst_n), .kif(if128));
  aes_key_expansion #(.nk(6), .nr(12)) u_dut192 (.clk(clk), .rst_n(rst_n), .kif(if192));
  aes_key_expansion #(.nk(8), .nr(14)) u_dut256 (.clk(clk), .rst_n(rst_n), .kif(if256));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if128.busy;
      1:       return if192.busy;
      default: return if256.busy;
    endcase
  endfunction

  function automatic logic get_valid(input int sel);
    case (sel)
      0:       return if128.valid;
      1:       return if192.valid;
      default: return if256.valid;
    endcase
  endfunction

  function automatic logic ks_any(input int sel);
    case (sel)
      0:       return |if128.keyschedule;
      1:       return |if192.keyschedule;
      default: return |if256.keyschedule;
    endcase
  endfunction

  function automatic logic [31:0] ks_word(input int sel, input int i);
    case (sel)
      0:       return if128.keyschedule[32*i +: 32];
      1:       return if192.keyschedule[32*i +: 32];
      default: return if256.keyschedule[32*i +: 32];
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if128.start = v;
      1:       if192.start = v;
      default: if256.start = v;
    endcase
  endtask

  // Called at a negedge; returns edges counted from the accepting edge (inclusive) to valid.
  task automatic run_expand(input int sel, input bit inject, output int edges);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    edges = 1;
    check_val($sformatf("busy_after_start_%0d", sel), 32'(get_busy(sel)), 32'd1);
    check_val($sformatf("valid_drop_%0d", sel), 32'(get_valid(sel)), 32'd0);
    while (!get_valid(sel) && edges < 200) begin
      if (inject && edges == 10) begin
        set_start(sel, 1'b1);
        if128.key = '1;
      end
      if (inject && edges == 11) set_start(sel, 1'b0);
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if128.start = 1'b0; if192.start = 1'b0; if256.start = 1'b0;
    if128.key = '0; if192.key = '0; if256.key = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("rst_busy_%0d", s), 32'(get_busy(s)), 32'd0);
      check_val($sformatf("rst_valid_%0d", s), 32'(get_valid(s)), 32'd0);
      check_val($sformatf("rst_ks_%0d", s), 32'(ks_any(s)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 with a start pulse and key change injected mid-run
    if128.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_expand(0, 1'b1, lat);
    check_val("lat128", 32'(lat), 32'd41);
    check_val("w128_0", ks_word(0, 0), 32'h2b7e1516);
    check_val("w128_4", ks_word(0, 4), 32'ha0fafe17);
    check_val("w128_5", ks_word(0, 5), 32'h88542cb1);
    check_val("w128_8", ks_word(0, 8), 32'hf2c295f2);
    check_val("w128_40", ks_word(0, 40), 32'hd014f9a8);
    check_val("w128_43", ks_word(0, 43), 32'hb6630ca6);
    check_val("busy128_done", 32'(get_busy(0)), 32'd0);
    repeat (3) @(negedge clk);
    check_val("valid128_hold", 32'(get_valid(0)), 32'd1);
    check_val("w128_43_hold", ks_word(0, 43), 32'hb6630ca6);

    if192.key = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    run_expand(1, 1'b0, lat);
    check_val("lat192", 32'(lat), 32'd47);
    check_val("w192_6", ks_word(1, 6), 32'hfe0c91f7);
    check_val("w192_51", ks_word(1, 51), 32'h01002202);

    if256.key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run_expand(2, 1'b0, lat);
    check_val("lat256", 32'(lat), 32'd53);
    check_val("w256_8", ks_word(2, 8), 32'h9ba35411);
    check_val("w256_12", ks_word(2, 12), 32'ha8b09c1a);
    check_val("w256_59", ks_word(2, 59), 32'h706c631e);

    // Reset abort mid-run
    if128.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(get_busy(0)), 32'd0);
    check_val("abort_valid", 32'(get_valid(0)), 32'd0);
    check_val("abort_ks128", 32'(ks_any(0)), 32'd0);
    check_val("abort_ks256", 32'(ks_any(2)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_expand(0, 1'b0, lat);
    check_val("lat128_after_rst", 32'(lat), 32'd41);
    check_val("w128_43_after_rst", ks_word(0, 43), 32'hb6630ca6);

    // Key change without start leaves schedule frozen; start then re-expands
    if128.key = '0;
    repeat (5) @(negedge clk);
    check_val("keychg_valid", 32'(get_valid(0)), 32'd1);
    check_val("keychg_w4", ks_word(0, 4), 32'ha0fafe17);
    check_val("keychg_w43", ks_word(0, 43), 32'hb6630ca6);
    run_expand(0, 1'b0, lat);
    check_val("lat128_zero", 32'(lat), 32'd41);
    check_val("zero_w4", ks_word(0, 4), 32'h62636363);
    check_val("zero_w40", ks_word(0, 40), 32'hb4ef5bcb);
    check_val("zero_w43", ks_word(0, 43), 32'h6f8f188e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
